// File: rtl/johnson_pkg.sv
// Package shared by the Johnson sequencer slice.
// Holds the legal stage limit, the step direction encoding and the helper
// that sizes the binary phase index.
package johnson_pkg;

    localparam int unsigned MAX_STAGES = 16;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

    // Width of the binary phase index for a ring of 'stages' flip-flops.
    function automatic int unsigned phase_w(input int unsigned stages);
        return $clog2(2 * stages);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational phase decoder for a Johnson counter.
// Ports:
//   j       in  STAGES  raw Johnson state bits
//   reset   in  1       forces decoded and phase to zero while high
//   decoded out P       one-hot phase (P = 2*STAGES)
//   phase   out PW      binary index of the active phase (0 when illegal)
//   illegal out 1       state is not a valid Johnson code
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int unsigned STAGES = 4,
    localparam int unsigned P      = 2 * STAGES,
    localparam int unsigned PW     = phase_w(STAGES)
) (
    input  logic [STAGES-1:0] j,
    input  logic              reset,
    output logic [P-1:0]      decoded,
    output logic [PW-1:0]     phase,
    output logic              illegal
);

    logic [P-1:0]  raw;
    logic [PW:0]   pop;
    logic [PW-1:0] idx;

    always_comb begin
        raw = '0;
        raw[0] = ~j[STAGES-1] & ~j[0];
        for (int unsigned k = 1; k < STAGES; k++) begin
            raw[k] = j[k-1] & ~j[k];
        end
        raw[STAGES] = j[STAGES-1] & j[0];
        for (int unsigned k = STAGES + 1; k < P; k++) begin
            raw[k] = ~j[k-STAGES-1] & j[k-STAGES];
        end
    end

    // Population count and index are derived from the raw decode so that an
    // illegal state is flagged even while reset masks the outputs.
    always_comb begin
        pop = '0;
        idx = '0;
        for (int unsigned k = 0; k < P; k++) begin
            pop = pop + {{PW{1'b0}}, raw[k]};
            if (raw[k]) begin
                idx = idx | PW'(k);
            end
        end
    end

    assign illegal = (pop != (PW+1)'(1));
    assign decoded = reset ? '0 : raw;
    assign phase   = (reset || illegal) ? '0 : idx;

endmodule

// File: rtl/johnson_seq.sv
// Johnson (inverted ring) phase sequencer with enable, re-align, wrap pulse
// and illegal-state recovery.
// Optional feature: define JOHNSON_SEQ_DIR_EN to honour DIR (backward steps).
// Ports:
//   CLK     in  1       rising-edge clock
//   RESET   in  1       synchronous active-high reset
//   EN      in  1       advance one phase
//   DIR     in  1       0 forward, 1 backward (only with JOHNSON_SEQ_DIR_EN)
//   SYNC    in  1       re-align to phase 0
//   DFF     out STAGES  raw state bits
//   Decoded out P       one-hot phase, combinational
//   PHASE   out PW      binary phase index, combinational
//   WRAP    out 1       registered one-cycle wrap pulse
//   ERR     out 1       sticky illegal-state flag
module johnson_seq
    import johnson_pkg::*;
#(
    parameter  int unsigned STAGES = 4,
    localparam int unsigned P      = 2 * STAGES,
    localparam int unsigned PW     = phase_w(STAGES)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              DIR,
    input  logic              SYNC,
    output logic [STAGES-1:0] DFF,
    output logic [P-1:0]      Decoded,
    output logic [PW-1:0]     PHASE,
    output logic              WRAP,
    output logic              ERR
);

    logic [STAGES-1:0] j_q;
    logic [STAGES-1:0] j_fwd;
    logic              wrap_q;
    logic              err_q;
    logic              illegal;

    johnson_decode #(
        .STAGES(STAGES)
    ) u_decode (
        .j      (j_q),
        .reset  (RESET),
        .decoded(Decoded),
        .phase  (PHASE),
        .illegal(illegal)
    );

    assign j_fwd = {j_q[STAGES-2:0], ~j_q[STAGES-1]};

`ifdef JOHNSON_SEQ_DIR_EN
    logic [STAGES-1:0] j_bwd;
    dir_e              dir;

    assign j_bwd = {~j_q[0], j_q[STAGES-1:1]};
    assign dir   = dir_e'(DIR);
`else
    logic unused_dir;

    assign unused_dir = DIR;
`endif

    // RESET masks Decoded, but that cannot matter here: RESET has top priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            j_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (illegal) begin
            j_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b1;
        end else if (SYNC) begin
            j_q    <= '0;
            wrap_q <= 1'b0;
        end else if (EN) begin
`ifdef JOHNSON_SEQ_DIR_EN
            if (dir == DIR_BWD) begin
                j_q    <= j_bwd;
                wrap_q <= Decoded[0];
            end else begin
                j_q    <= j_fwd;
                wrap_q <= Decoded[P-1];
            end
`else
            j_q    <= j_fwd;
            wrap_q <= Decoded[P-1];
`endif
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign DFF  = j_q;
    assign WRAP = wrap_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_johnson_seq.sv
module tb_johnson_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic dir = 1'b0;
    logic sync = 1'b0;

    logic [3:0]  dff4;
    logic [7:0]  dec4;
    logic [2:0]  ph4;
    logic        wrap4, err4;
    logic [1:0]  dff2;
    logic [3:0]  dec2;
    logic [1:0]  ph2;
    logic        wrap2, err2;
    logic [15:0] dff16;
    logic [31:0] dec16;
    logic [4:0]  ph16;
    logic        wrap16, err16;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    johnson_seq #(.STAGES(4)) dut4 (
        .CLK(clk), .RESET(reset), .EN(en), .DIR(dir), .SYNC(sync),
        .DFF(dff4), .Decoded(dec4), .PHASE(ph4), .WRAP(wrap4), .ERR(err4)
    );
    johnson_seq #(.STAGES(2)) dut2 (
        .CLK(clk), .RESET(reset), .EN(en), .DIR(dir), .SYNC(sync),
        .DFF(dff2), .Decoded(dec2), .PHASE(ph2), .WRAP(wrap2), .ERR(err2)
    );
    johnson_seq #(.STAGES(16)) dut16 (
        .CLK(clk), .RESET(reset), .EN(en), .DIR(dir), .SYNC(sync),
        .DFF(dff16), .Decoded(dec16), .PHASE(ph16), .WRAP(wrap16), .ERR(err16)
    );

    // Reference model: phase kept as a plain integer modulo P per instance.
    int unsigned ns[3] = '{4, 2, 16};
    int          m_ph[3];
    bit          m_wrap[3];
    bit          m_err[3];
    bit          m_ill[3];

    function automatic logic [31:0] jcode(input int k, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r[i] = (i < k) && (i + n >= k);
        end
        return r;
    endfunction

    task automatic model_edge();
        bit back;
`ifdef JOHNSON_SEQ_DIR_EN
        back = dir;
`else
        back = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            int p;
            p = 2 * ns[i];
            if (reset) begin
                m_ph[i] = 0; m_wrap[i] = 0; m_err[i] = 0; m_ill[i] = 0;
            end else if (m_ill[i]) begin
                m_ph[i] = 0; m_wrap[i] = 0; m_err[i] = 1; m_ill[i] = 0;
            end else if (sync) begin
                m_ph[i] = 0; m_wrap[i] = 0;
            end else if (en) begin
                if (back) begin
                    m_wrap[i] = (m_ph[i] == 0);
                    m_ph[i]   = (m_ph[i] + p - 1) % p;
                end else begin
                    m_wrap[i] = (m_ph[i] == p - 1);
                    m_ph[i]   = (m_ph[i] + 1) % p;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a_dff, a_dec, a_ph, e_dec, e_ph;
            logic        a_wrap, a_err;
            int          n;
            n = int'(ns[i]);
            case (i)
                0: begin a_dff = 32'(dff4); a_dec = 32'(dec4); a_ph = 32'(ph4); a_wrap = wrap4; a_err = err4; end
                1: begin a_dff = 32'(dff2); a_dec = 32'(dec2); a_ph = 32'(ph2); a_wrap = wrap2; a_err = err2; end
                default: begin a_dff = 32'(dff16); a_dec = dec16; a_ph = 32'(ph16); a_wrap = wrap16; a_err = err16; end
            endcase
            e_dec = reset ? 32'd0 : (32'd1 << m_ph[i]);
            e_ph  = (reset || m_ill[i]) ? 32'd0 : 32'(m_ph[i]);
            if (!m_ill[i]) begin
                chk($sformatf("s%0d.dff", n), a_dff, jcode(m_ph[i], n));
                chk($sformatf("s%0d.decoded", n), a_dec, e_dec);
            end
            chk($sformatf("s%0d.phase", n), a_ph, e_ph);
            chk($sformatf("s%0d.wrap", n), 32'(a_wrap), 32'(m_wrap[i]));
            chk($sformatf("s%0d.err", n), 32'(a_err), 32'(m_err[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit sync;
        int ph;
        bit wrap;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        int   guard;

        vecs = '{
            '{1,0,0,0,0}, '{1,0,0,0,0},
            '{0,1,0,1,0}, '{0,1,0,2,0}, '{0,1,0,3,0}, '{0,1,0,4,0},
            '{0,1,0,5,0}, '{0,1,0,6,0}, '{0,1,0,7,0}, '{0,1,0,0,1},
            '{0,1,0,1,0}, '{0,1,0,2,0},
            '{0,1,0,3,0}, '{0,0,0,3,0}, '{0,0,0,3,0}, '{0,1,0,4,0},
            '{0,1,0,5,0}, '{0,1,1,0,0}
        };

        @(negedge clk);
        for (int v = 0; v < 18; v++) begin
            reset = vecs[v].rst; en = vecs[v].en; sync = vecs[v].sync; dir = 1'b0;
            step();
            chk($sformatf("vec%0d.phase", v), 32'(ph4), 32'(vecs[v].ph));
            chk($sformatf("vec%0d.wrap", v), 32'(wrap4), 32'(vecs[v].wrap));
        end
        sync = 1'b0;
        chk("sync.dff", 32'(dff4), 32'h0);

`ifdef JOHNSON_SEQ_DIR_EN
        reset = 1'b1; en = 1'b0;
        step();
        reset = 1'b0; dir = 1'b1; en = 1'b1;
        step(); chk("bwd1.phase", 32'(ph4), 32'd7); chk("bwd1.wrap", 32'(wrap4), 32'd1);
        step(); chk("bwd2.phase", 32'(ph4), 32'd6); chk("bwd2.wrap", 32'(wrap4), 32'd0);
        step(); chk("bwd3.phase", 32'(ph4), 32'd5);
        dir = 1'b0;
`endif

        // Illegal state injected into the 4-stage instance.
        en = 1'b1;
        step(); step();
        en = 1'b0;
        force dut4.j_q = 4'b0101;
        m_ill[0] = 1;
        #1;
        chk("illegal.phase", 32'(ph4), 32'd0);
        chk("illegal.err_before", 32'(err4), 32'd0);
        release dut4.j_q;
        step();
        chk("recover.dff", 32'(dff4), 32'h0);
        chk("recover.err", 32'(err4), 32'd1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("err_sticky_sync", 32'(err4), 32'd1);

        // Walk to phase 6, then reset mid-sequence.
        en = 1'b1;
        guard = 0;
        while (m_ph[0] != 6 && guard < 20) begin
            step();
            guard++;
        end
        chk("reach_phase6", 32'(ph4), 32'd6);
        en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset.decoded", 32'(dec4), 32'h0);
        check_all();
        step();
        chk("midreset.dff", 32'(dff4), 32'h0);
        reset = 1'b0;
        #1;
        chk("release.decoded", 32'(dec4), 32'h1);
        chk("release.err", 32'(err4), 32'd0);

        // Full rotation of every instance, including the 32-phase one.
        en = 1'b1;
        for (int c = 0; c < 34; c++) begin
            step();
        end

        // Randomized stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 9) < 7);
            sync  = ($urandom_range(0, 19) == 0);
            dir   = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/johnson_seq.md
# johnson_seq

Parametrised Johnson (inverted ring) sequencer with STAGES flip-flops producing 2·STAGES one-hot phases. It adds advance enable, optional reverse stepping, synchronous re-align, a binary phase index, a wrap pulse, and illegal-state detection with recovery. It serves as the drop-in phase generator for multi-phase mux and strobe logic, generalising the fixed 4-DFF / 8-phase sequencer.

## Interface
- STAGES, default 4: number of state flip-flops, legal range 2..16; phase count P = 2·STAGES.
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  advance one phase on this edge when high.
- DIR  in  1  0 = forward, 1 = backward. Ignored unless JOHNSON_SEQ_DIR_EN is defined.
- SYNC  in  1  synchronous re-align to phase 0.
- DFF  out  STAGES  raw state bits J.
- Decoded  out  P  one-hot phase, combinational from J and RESET.
- PHASE  out  clog2(P)  binary index of the active phase, combinational.
- WRAP  out  1  registered one-cycle wrap pulse.
- ERR  out  1  sticky illegal-state flag.

## Operation
- Reset values (first edge with RESET=1): J=0, WRAP=0, ERR=0.
- While RESET=1: Decoded=0 and PHASE=0 combinationally, regardless of J.
- Forward step: J ← {J[STAGES-2:0], ~J[STAGES-1]}.
- Backward step: J ← {~J[0], J[STAGES-1:1]}.
- Forward sequence for STAGES=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then repeats.
- Decode, with N = STAGES:
  - k=0: ~J[N-1]&~J[0].
  - k=1..N-1: J[k-1]&~J[k].
  - k=N: J[N-1]&J[0].
  - k=N+1..P-1: ~J[k-N-1]&J[k-N].
- PHASE = index of the set Decoded bit.
- Illegal state: J is not a valid Johnson code (Decoded population ≠ 1). While illegal, PHASE=0. On the next edge, J ← 0 and ERR ← 1. ERR clears only on RESET.
- Priority on each edge: RESET > illegal recovery > SYNC > EN. Lower items are ignored when a higher one acts.
- SYNC: J ← 0. No WRAP is raised.
- WRAP ← 1 for exactly one cycle after either:
  - a forward EN step from phase P-1 to phase 0, or
  - a backward step from phase 0 to phase P-1.
- WRAP is 0 for every other edge, including SYNC, recovery, and RESET.
- EN=0: J holds and WRAP ← 0.

## Timing
- All state changes occur on the rising CLK edge.
- Decoded and PHASE reflect the new J in the same cycle after the edge (zero added latency). They are glitch-permitted combinational outputs.
- WRAP is registered and aligns with the cycle in which the new phase is first visible.
- Reset is synchronous. Asserting RESET mid-sequence forces Decoded=0 immediately and J=0 at the next edge. After release, Decoded[0]=1 with no extra cycle.
- EN=1 continuously gives a period of P cycles per phase rotation.
- Simultaneous SYNC and EN: SYNC wins and the phase becomes 0.
- Simultaneous DIR change and EN: the step uses the DIR value sampled at that edge.

## Configuration
- JOHNSON_SEQ_DIR_EN defined: DIR is honoured and backward stepping and backward WRAP are implemented.
- JOHNSON_SEQ_DIR_EN undefined: DIR is unconnected internally, stepping is forward only, and the backward-step logic is absent.

## Structure
- Package johnson_pkg holds:
  - function phase_w(stages) = clog2(2·stages);
  - localparam MAX_STAGES = 16;
  - enum dir_e {DIR_FWD=0, DIR_BWD=1}.
- Sub-module johnson_decode (combinational): J[STAGES] and RESET in; Decoded[P], PHASE, and illegal flag out. The top holds the state register, step/priority logic, WRAP, and ERR.

## Test plan
- RESET for 2 cycles, then EN=1 for 9 cycles, STAGES=4 → Decoded walks 0x01, 0x02, … 0x80, 0x01. WRAP is high only in the cycle Decoded returns to 0x01. PHASE reads 0..7, 0.
- EN toggled 1,0,0,1 from phase 2 → phase 3 holds for 2 cycles, then 4. WRAP stays 0.
- SYNC=1 with EN=1 at phase 5 → next cycle phase 0, DFF=0000, WRAP=0.
- With JOHNSON_SEQ_DIR_EN, DIR=1, EN=1 from reset → PHASE 7, 6, 5. WRAP is high in the cycle PHASE=7 first appears.
- Deposit J=0101 (illegal) → PHASE=0 that cycle. The next edge gives J=0000 and ERR=1. ERR persists through SYNC and clears only on RESET.
- Assert RESET at phase 6 → Decoded=0 immediately. After the edge, J=0000. Release gives Decoded=0x01 and ERR=0. Repeat with STAGES=2 (P=4) and STAGES=16 (P=32) for a full rotation each.
